// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back/write-allocate data cache, 4 words per line
module data_cache #(
    parameter int LINE_COUNT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         is_input_valid,
    input  logic [31:0]  addr,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  din,
    output logic         is_ready,
    output logic         is_output_valid,
    output logic [31:0]  dout,
    output logic         is_hit,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count,
    output logic         mem_req_valid,
    output logic         mem_req_write,
    output logic [31:0]  mem_req_addr,
    output logic [127:0] mem_req_data,
    input  logic         mem_req_ready,
    input  logic         mem_resp_valid,
    input  logic [127:0] mem_resp_data
);
    localparam int IW = $clog2(LINE_COUNT);
    localparam int TW = 28 - IW;

    typedef enum logic [1:0] {IDLE, TAG_CHECK, WRITEBACK, ALLOCATE} state_t;

    state_t      state_q, state_d;
    logic [29:0] waddr_q, waddr_d;
    logic [31:0] din_q, din_d;
    logic        is_write_q, is_write_d;
    logic        first_q, first_d;
    logic        fill_wait_q, fill_wait_d;
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    logic          valid_q [LINE_COUNT];
    logic          dirty_q [LINE_COUNT];
    logic [TW-1:0] tag_q   [LINE_COUNT];
    logic [127:0]  data_q  [LINE_COUNT];

    logic [IW-1:0] idx;
    logic [TW-1:0] req_tag;
    logic [1:0]    off;
    logic          lookup_hit;
    logic          victim_dirty;
    logic [127:0]  cur_line;

    logic          line_we;
    logic [127:0]  line_data;
    logic          line_dirty;

    // Byte-offset bits never reach the cache; word accesses only.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    assign idx          = waddr_q[1+IW:2];
    assign req_tag      = waddr_q[29:2+IW];
    assign off          = waddr_q[1:0];
    assign cur_line     = data_q[idx];
    assign lookup_hit   = valid_q[idx] && (tag_q[idx] == req_tag);
    assign victim_dirty = valid_q[idx] && dirty_q[idx];
    assign hit_count    = hit_count_q;
    assign miss_count   = miss_count_q;

    always_comb begin
        state_d         = state_q;
        waddr_d         = waddr_q;
        din_d           = din_q;
        is_write_d      = is_write_q;
        first_d         = first_q;
        fill_wait_d     = fill_wait_q;
        hit_count_d     = hit_count_q;
        miss_count_d    = miss_count_q;
        is_ready        = 1'b0;
        is_output_valid = 1'b0;
        is_hit          = 1'b0;
        dout            = 32'h0;
        mem_req_valid   = 1'b0;
        mem_req_write   = 1'b0;
        mem_req_addr    = 32'h0;
        mem_req_data    = 128'h0;
        line_we         = 1'b0;
        line_data       = cur_line;
        line_dirty      = 1'b0;

        case (state_q)
            IDLE: begin
                is_ready = 1'b1;
                if (is_input_valid && (mem_read || mem_write)) begin
                    waddr_d    = addr[31:2];
                    din_d      = din;
                    is_write_d = mem_write;
                    first_d    = 1'b1;
                    state_d    = TAG_CHECK;
                end
            end
            TAG_CHECK: begin
                if (lookup_hit) begin
                    is_output_valid = 1'b1;
                    is_hit          = first_q;
                    state_d         = IDLE;
                    if (first_q && hit_count_q != 32'hFFFF_FFFF)
                        hit_count_d = hit_count_q + 32'd1;
                    if (is_write_q) begin
                        line_we                     = 1'b1;
                        line_data[{off, 5'b0} +: 32] = din_q;
                        line_dirty                  = 1'b1;
                    end else begin
                        dout = cur_line[{off, 5'b0} +: 32];
                    end
                end else begin
                    if (first_q && miss_count_q != 32'hFFFF_FFFF)
                        miss_count_d = miss_count_q + 32'd1;
                    first_d     = 1'b0;
                    fill_wait_d = 1'b0;
                    state_d     = victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = {tag_q[idx], idx, 4'b0};
                mem_req_data  = cur_line;
                if (mem_req_ready)
                    state_d = ALLOCATE;
            end
            ALLOCATE: begin
                if (!fill_wait_q) begin
                    mem_req_valid = 1'b1;
                    mem_req_addr  = {waddr_q[29:2], 4'b0};
                    if (mem_req_ready)
                        fill_wait_d = 1'b1;
                end else if (mem_resp_valid) begin
                    line_we   = 1'b1;
                    line_data = mem_resp_data;
                    state_d   = TAG_CHECK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            waddr_q      <= '0;
            din_q        <= '0;
            is_write_q   <= 1'b0;
            first_q      <= 1'b0;
            fill_wait_q  <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            for (int i = 0; i < LINE_COUNT; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            din_q        <= din_d;
            is_write_q   <= is_write_d;
            first_q      <= first_d;
            fill_wait_q  <= fill_wait_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            if (line_we) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= line_dirty;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[idx]  <= req_tag;
            data_q[idx] <= line_data;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - randomized bench for data_cache against a flat-memory reference model
module tb_data_cache;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         is_input_valid = 1'b0;
    logic [31:0]  addr = '0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [31:0]  din = '0;
    logic         is_ready, is_output_valid, is_hit;
    logic [31:0]  dout, hit_count, miss_count;
    logic         mem_req_valid, mem_req_write;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_req_ready = 1'b0;
    logic         mem_resp_valid = 1'b0;
    logic [127:0] mem_resp_data = '0;

    always #5 clk = ~clk;

    data_cache #(.LINE_COUNT(16)) dut (
        .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
        .mem_read(mem_read), .mem_write(mem_write), .din(din),
        .is_ready(is_ready), .is_output_valid(is_output_valid), .dout(dout), .is_hit(is_hit),
        .hit_count(hit_count), .miss_count(miss_count),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: CPU-visible memory, backing memory, and which block each index holds.
    logic [31:0] gold [logic [31:0]];
    logic [31:0] bmem [logic [31:0]];
    bit          res_valid [16];
    bit          res_dirty [16];
    logic [31:0] res_tag   [16];
    logic [31:0] exp_hits, exp_miss;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return {wa[15:0] ^ 16'h5A5A, ~wa[15:0]};
    endfunction

    function automatic logic [31:0] gold_rd(input logic [31:0] wa);
        return gold.exists(wa) ? gold[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] bmem_rd(input logic [31:0] wa);
        return bmem.exists(wa) ? bmem[wa] : init_word(wa);
    endfunction

    function automatic logic [127:0] gold_blk(input logic [31:0] ba);
        return {gold_rd((ba >> 2) + 3), gold_rd((ba >> 2) + 2), gold_rd((ba >> 2) + 1), gold_rd(ba >> 2)};
    endfunction

    function automatic logic [127:0] bmem_blk(input logic [31:0] ba);
        return {bmem_rd((ba >> 2) + 3), bmem_rd((ba >> 2) + 2), bmem_rd((ba >> 2) + 1), bmem_rd(ba >> 2)};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            res_valid[i] = 0;
            res_dirty[i] = 0;
            res_tag[i]   = '0;
        end
        exp_hits = '0;
        exp_miss = '0;
        gold = bmem;
    endtask

    task automatic access(input logic [31:0] a, input bit wr, input logic [31:0] d, input int wb_stall);
        int idx, cyc, nwb, nfill, resp_cd, stall, n;
        logic [31:0] tg, blk, vblk;
        bit exp_hit, exp_wb, done, responded;
        idx     = int'(a[7:4]);
        tg      = a >> 8;
        blk     = {a[31:4], 4'b0};
        exp_hit = res_valid[idx] && res_tag[idx] == tg;
        exp_wb  = !exp_hit && res_valid[idx] && res_dirty[idx];
        vblk    = (res_tag[idx] << 8) | (idx << 4);

        @(negedge clk);
        n = 0;
        while (!is_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_idle", is_ready, 1);
        check("hit_count", hit_count, exp_hits);
        check("miss_count", miss_count, exp_miss);
        is_input_valid = 1;
        addr      = a;
        mem_read  = !wr || ($urandom % 4 == 0);
        mem_write = wr;
        din       = d;
        @(posedge clk);
        #1;
        // Garbage on the CPU side while busy must be ignored.
        is_input_valid = 1'($urandom);
        mem_read  = 1'($urandom);
        mem_write = 1'($urandom);
        addr      = $urandom;
        din       = $urandom;

        done = 0; cyc = 0; nwb = 0; nfill = 0; resp_cd = -1; responded = 0; stall = wb_stall;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            mem_resp_valid = 0;
            mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
            if (is_output_valid) begin
                done = 1;
                is_input_valid = 0; mem_read = 0; mem_write = 0; mem_req_ready = 0;
                check("is_hit", is_hit, exp_hit);
                if (!wr) check("dout", dout, gold_rd(a >> 2));
                check("wb_count", nwb, exp_wb);
                check("fill_count", nfill, !exp_hit);
                if (exp_hit) check("hit_latency", cyc, 1);
            end else begin
                check("busy_not_ready", is_ready, 0);
                if (resp_cd == 0) begin
                    mem_resp_valid = 1;
                    mem_resp_data  = bmem_blk(blk);
                    responded = 1;
                    resp_cd = -1;
                end else if (resp_cd > 0) begin
                    resp_cd--;
                end else if ((nfill == 0 || responded) && $urandom % 6 == 0) begin
                    mem_resp_valid = 1;
                end
                if (mem_req_valid) begin
                    if (mem_req_write) begin
                        check("wb_addr", mem_req_addr, vblk);
                        check("wb_data", mem_req_data, gold_blk(vblk));
                        mem_req_ready = (stall > 0) ? 1'b0 : 1'($urandom);
                        if (stall > 0) stall--;
                    end else begin
                        check("fill_addr", mem_req_addr, blk);
                        mem_req_ready = 1'($urandom);
                    end
                    if (mem_req_ready) begin
                        if (mem_req_write) begin
                            for (int w = 0; w < 4; w++)
                                bmem[(vblk >> 2) + w] = gold_rd((vblk >> 2) + w);
                            nwb++;
                        end else begin
                            nfill++;
                            resp_cd = int'($urandom % 3);
                        end
                    end
                end else begin
                    mem_req_ready = 1'($urandom);
                end
            end
        end
        if (!done) begin
            check("access_timeout", 0, 1);
            is_input_valid = 0; mem_read = 0; mem_write = 0;
        end
        mem_req_ready  = 0;
        mem_resp_valid = 0;

        if (exp_hit) exp_hits = sat_inc(exp_hits);
        else         exp_miss = sat_inc(exp_miss);
        if (!exp_hit) begin
            res_valid[idx] = 1;
            res_tag[idx]   = tg;
            res_dirty[idx] = 0;
        end
        if (wr) begin
            res_dirty[idx] = 1;
            gold[a >> 2]   = d;
        end
        @(negedge clk);
        check("pulse_one_cycle", is_output_valid, 0);
    endtask

    initial begin
        int n;
        bmem[32'h100 >> 2] = 32'hDEAD_BEEF;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        check("rst_ready", is_ready, 1);
        check("rst_out_valid", is_output_valid, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_is_hit", is_hit, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);

        access(32'h100, 0, 0, 0);
        access(32'h100, 0, 0, 0);
        access(32'h104, 1, 32'h1234, 0);
        access(32'h1100, 0, 0, 5);
        check("wb_word1_mem", bmem_rd(32'h104 >> 2), 32'h1234);
        access(32'h230, 1, 32'hCAFE_F00D, 0);

        // Abort a fill with reset and confirm dirty data and counters are gone.
        @(negedge clk);
        is_input_valid = 1; addr = 32'h2100; mem_read = 1; mem_write = 0;
        @(posedge clk);
        #1;
        is_input_valid = 0; mem_read = 0;
        n = 0;
        @(negedge clk);
        while (!(mem_req_valid && !mem_req_write) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_fill_req", mem_req_valid && !mem_req_write, 1);
        mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0;
        check("abort_wait_no_req", mem_req_valid, 0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("abort_req_valid", mem_req_valid, 0);
        check("abort_out_valid", is_output_valid, 0);
        check("abort_ready", is_ready, 1);
        check("abort_hit_count", hit_count, 0);
        check("abort_miss_count", miss_count, 0);
        mem_resp_valid = 1;
        mem_resp_data  = {4{32'hBAD0_BAD0}};
        @(negedge clk);
        mem_resp_valid = 0;
        model_reset();
        access(32'h100, 0, 0, 0);
        access(32'h230, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = (($urandom % 4) << 8) | (($urandom % 16) << 4) | (($urandom % 4) << 2);
            access(a, 1'($urandom % 3 == 0), $urandom, int'($urandom % 3));
        end

        access(32'h100, 0, 0, 0);
        @(negedge clk);
        force dut.hit_count_q = 32'hFFFF_FFFD;
        @(posedge clk);
        #1;
        release dut.hit_count_q;
        exp_hits = 32'hFFFF_FFFD;
        for (int i = 0; i < 4; i++) access(32'h100 | (i << 2), 0, 0, 0);
        check("hit_count_saturated", hit_count, 32'hFFFF_FFFF);
        check("miss_count_final", miss_count, exp_miss);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
